// File: rtl/hand_pose_smoother.sv
// rtl/hand_pose_smoother.sv - shift-based EMA smoother for six hand coordinates plus direction vector
module hand_pose_smoother #(
    parameter int ALPHA_SHIFT = 2,
    parameter int JUMP_THRESH = 256
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sample_in,
    input  logic [11:0] hand_x_bottom,
    input  logic [11:0] hand_y_bottom,
    input  logic [13:0] hand_z_bottom,
    input  logic [11:0] hand_x_top,
    input  logic [11:0] hand_y_top,
    input  logic [13:0] hand_z_top,
    output logic [11:0] smooth_x_bottom,
    output logic [11:0] smooth_y_bottom,
    output logic [13:0] smooth_z_bottom,
    output logic [11:0] smooth_x_top,
    output logic [11:0] smooth_y_top,
    output logic [13:0] smooth_z_top,
    output logic [12:0] dir_x,
    output logic [12:0] dir_y,
    output logic [14:0] dir_z,
    output logic        out_valid,
    output logic        busy,
    output logic        sample_dropped
);
    // All six lanes share the widest (14-bit) storage so one datapath can index them.
    localparam int AW = 14 + ALPHA_SHIFT;

    typedef enum logic [1:0] {IDLE, FILTER, DIR, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [2:0]     idx;
    logic           primed;
    logic [13:0]    snap [0:5];
    logic [AW-1:0]  acc  [0:5];

    logic [AW-1:0]  cur_acc;
    logic [AW-1:0]  cur_m;
    logic [AW-1:0]  cur_s;
    logic [AW-1:0]  mag;
    logic           snap_now;
    logic [AW-1:0]  acc_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_in) state_next = FILTER;
            FILTER:  if (idx == 3'd5) state_next = DIR;
            DIR:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cur_acc  = acc[idx];
        cur_m    = cur_acc >> ALPHA_SHIFT;
        cur_s    = AW'(snap[idx]);
        mag      = (cur_s >= cur_m) ? (cur_s - cur_m) : (cur_m - cur_s);
        snap_now = !primed || (mag > AW'(JUMP_THRESH));
        // acc - m never goes negative because m is acc with its fraction bits dropped.
        acc_next = snap_now ? (cur_s << ALPHA_SHIFT) : (cur_acc + cur_s - cur_m);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            idx            <= 3'd0;
            primed         <= 1'b0;
            sample_dropped <= 1'b0;
            dir_x          <= '0;
            dir_y          <= '0;
            dir_z          <= '0;
            for (int i = 0; i < 6; i++) begin
                acc[i]  <= '0;
                snap[i] <= '0;
            end
        end else begin
            state          <= state_next;
            sample_dropped <= sample_in && (state != IDLE);
            case (state)
                IDLE: begin
                    if (sample_in) begin
                        snap[0] <= {2'b00, hand_x_bottom};
                        snap[1] <= {2'b00, hand_y_bottom};
                        snap[2] <= hand_z_bottom;
                        snap[3] <= {2'b00, hand_x_top};
                        snap[4] <= {2'b00, hand_y_top};
                        snap[5] <= hand_z_top;
                        idx     <= 3'd0;
                    end
                end
                FILTER: begin
                    acc[idx] <= acc_next;
                    idx      <= idx + 3'd1;
                end
                DIR: begin
                    dir_x <= {1'b0, smooth_x_top} - {1'b0, smooth_x_bottom};
                    dir_y <= {1'b0, smooth_y_top} - {1'b0, smooth_y_bottom};
                    dir_z <= {1'b0, smooth_z_top} - {1'b0, smooth_z_bottom};
                end
                DONE: begin
                    primed <= 1'b1;
                    idx    <= 3'd0;
                end
                default: ;
            endcase
        end
    end

    assign smooth_x_bottom = acc[0][ALPHA_SHIFT +: 12];
    assign smooth_y_bottom = acc[1][ALPHA_SHIFT +: 12];
    assign smooth_z_bottom = acc[2][ALPHA_SHIFT +: 14];
    assign smooth_x_top    = acc[3][ALPHA_SHIFT +: 12];
    assign smooth_y_top    = acc[4][ALPHA_SHIFT +: 12];
    assign smooth_z_top    = acc[5][ALPHA_SHIFT +: 14];

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
endmodule

// File: tb/tb_hand_pose_smoother.sv
// tb/tb_hand_pose_smoother.sv - randomized self-checking bench for hand_pose_smoother
module tb_hand_pose_smoother;
    localparam int AS = 2;
    localparam int TH = 256;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        sample_in = 1'b0;
    logic [11:0] hand_x_bottom = '0, hand_y_bottom = '0, hand_x_top = '0, hand_y_top = '0;
    logic [13:0] hand_z_bottom = '0, hand_z_top = '0;
    logic [11:0] smooth_x_bottom, smooth_y_bottom, smooth_x_top, smooth_y_top;
    logic [13:0] smooth_z_bottom, smooth_z_top;
    logic [12:0] dir_x, dir_y;
    logic [14:0] dir_z;
    logic        out_valid, busy, sample_dropped;

    int compared = 0;
    int mismatched = 0;
    int cur [6];
    int macc [6];
    bit mprimed;

    hand_pose_smoother #(.ALPHA_SHIFT(AS), .JUMP_THRESH(TH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in),
        .hand_x_bottom(hand_x_bottom), .hand_y_bottom(hand_y_bottom), .hand_z_bottom(hand_z_bottom),
        .hand_x_top(hand_x_top), .hand_y_top(hand_y_top), .hand_z_top(hand_z_top),
        .smooth_x_bottom(smooth_x_bottom), .smooth_y_bottom(smooth_y_bottom),
        .smooth_z_bottom(smooth_z_bottom), .smooth_x_top(smooth_x_top),
        .smooth_y_top(smooth_y_top), .smooth_z_top(smooth_z_top),
        .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z),
        .out_valid(out_valid), .busy(busy), .sample_dropped(sample_dropped)
    );

    always #5 clk_in = ~clk_in;

    wire [116:0] obs = {smooth_x_bottom, smooth_y_bottom, smooth_z_bottom, smooth_x_top,
                        smooth_y_top, smooth_z_top, dir_x, dir_y, dir_z};

    // Reference: each coordinate follows m + (s - m)/2^AS with sub-unit remainder kept, snapping on big jumps.
    function automatic void model_update();
        for (int i = 0; i < 6; i++) begin
            int m = macc[i] / (1 << AS);
            int d = (cur[i] > m) ? cur[i] - m : m - cur[i];
            if (!mprimed || d > TH) macc[i] = cur[i] * (1 << AS);
            else                    macc[i] = macc[i] + cur[i] - m;
        end
        mprimed = 1'b1;
    endfunction

    function automatic logic [116:0] exp_vec();
        int sm [6];
        for (int i = 0; i < 6; i++) sm[i] = macc[i] / (1 << AS);
        return {12'(sm[0]), 12'(sm[1]), 14'(sm[2]), 12'(sm[3]), 12'(sm[4]), 14'(sm[5]),
                13'(sm[3] - sm[0]), 13'(sm[4] - sm[1]), 15'(sm[5] - sm[2])};
    endfunction

    task automatic apply_inputs();
        hand_x_bottom = 12'(cur[0]); hand_y_bottom = 12'(cur[1]); hand_z_bottom = 14'(cur[2]);
        hand_x_top    = 12'(cur[3]); hand_y_top    = 12'(cur[4]); hand_z_top    = 14'(cur[5]);
    endtask

    task automatic scramble();
        hand_x_bottom = 12'($urandom); hand_y_bottom = 12'($urandom); hand_z_bottom = 14'($urandom);
        hand_x_top    = 12'($urandom); hand_y_top    = 12'($urandom); hand_z_top    = 14'($urandom);
    endtask

    task automatic set_cur(input int xb, input int yb, input int zb, input int xt, input int yt, input int zt);
        cur[0] = xb; cur[1] = yb; cur[2] = zb; cur[3] = xt; cur[4] = yt; cur[5] = zt;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1; sample_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < 6; i++) macc[i] = 0;
        mprimed = 1'b0;
    endtask

    task automatic send();
        @(negedge clk_in);
        apply_inputs();
        sample_in = 1'b1;
        model_update();
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            sample_in = 1'b0;
            if (k == 1) scramble();
            if (out_valid) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if ({obs, out_valid, busy, sample_dropped} !== 120'd0) begin
            mismatched++;
            $display("FAIL reset_state: got %h busy=%b ov=%b drop=%b, want all zero", obs, busy, out_valid, sample_dropped);
        end
    endtask

    task automatic test_prime();
        int lat;
        do_reset();
        set_cur(1800, 1800, 0, 1800, 1800, 0);
        send();
        @(negedge clk_in);
        sample_in = 1'b0;
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL prime_busy: got %b want 1", busy); end
        wait_valid(lat);
        lat = lat + 1;
        compared++;
        if (lat != 8) begin mismatched++; $display("FAIL prime_latency: got %0d want 8", lat); end
        compared++;
        if (smooth_x_bottom !== 12'd1800 || dir_x !== 13'd0 || dir_y !== 13'd0 || dir_z !== 15'd0) begin
            mismatched++;
            $display("FAIL prime_values: got xb=%0d dir=%h/%h/%h want 1800 and zero dirs", smooth_x_bottom, dir_x, dir_y, dir_z);
        end
    endtask

    task automatic test_ema();
        int lat;
        int want [2] = '{1004, 1007};
        do_reset();
        set_cur(1000, 0, 0, 0, 0, 0);
        send(); wait_valid(lat);
        for (int r = 0; r < 2; r++) begin
            set_cur(1016, 0, 0, 0, 0, 0);
            send(); wait_valid(lat);
            compared++;
            if (lat != 8 || smooth_x_bottom !== 12'(want[r]) || obs !== exp_vec()) begin
                mismatched++;
                $display("FAIL ema_step%0d: got xb=%0d lat=%0d want xb=%0d lat=8", r, smooth_x_bottom, lat, want[r]);
            end
        end
    endtask

    task automatic test_wrap();
        int lat;
        do_reset();
        set_cur(3392, 0, 0, 0, 0, 0);
        send(); wait_valid(lat);
        set_cur(0, 0, 0, 0, 0, 0);
        send(); wait_valid(lat);
        compared++;
        if (smooth_x_bottom !== 12'd0 || obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL wrap_snap: got xb=%0d want 0", smooth_x_bottom);
        end
    endtask

    task automatic test_dir();
        int lat;
        do_reset();
        set_cur(1800, 20, 0, 1700, 4000, 500);
        send(); wait_valid(lat);
        compared++;
        if (dir_x !== 13'h1F9C || dir_z !== 15'd500 || obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL dir_vector: got dx=%h dz=%h obs=%h want dx=1f9c dz=01f4 obs=%h", dir_x, dir_z, obs, exp_vec());
        end
    endtask

    task automatic test_dropped();
        int first, nv;
        first = -1; nv = 0;
        set_cur(1500, 1490, 9000, 1510, 1520, 9100);
        send();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            sample_in = (k == 3);
            if (k == 1 || k == 3) scramble();
            if (k == 4) begin
                compared++;
                if (sample_dropped !== 1'b1) begin mismatched++; $display("FAIL drop_pulse: got %b want 1", sample_dropped); end
            end
            if (out_valid) begin
                nv++;
                if (first < 0) first = k;
                if (k == 8) begin
                    compared++;
                    if (obs !== exp_vec()) begin mismatched++; $display("FAIL drop_values: got %h want %h", obs, exp_vec()); end
                end
            end
        end
        compared++;
        if (first != 8 || nv != 1) begin mismatched++; $display("FAIL drop_single_valid: first=%0d count=%0d want 8/1", first, nv); end
    endtask

    task automatic test_back_to_back();
        int lat;
        set_cur(1200, 1300, 5000, 1250, 1350, 5050);
        send(); wait_valid(lat);
        scramble();
        sample_in = 1'b1;
        @(negedge clk_in);
        compared++;
        if (sample_dropped !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL done_drop: got drop=%b busy=%b want 1/0", sample_dropped, busy);
        end
        set_cur(1210, 1290, 5020, 1260, 1340, 5070);
        apply_inputs();
        model_update();
        wait_valid(lat);
        compared++;
        if (lat != 8 || obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL back_to_back: lat=%0d got %h want lat=8 %h", lat, obs, exp_vec());
        end
    endtask

    task automatic test_random();
        int lat, w, v;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 6; i++) begin
                w = (i == 2 || i == 5) ? 16383 : 4095;
                if ($urandom_range(0, 3) != 0) begin
                    v = cur[i] + int'($urandom_range(0, 600)) - 300;
                    cur[i] = (v < 0) ? 0 : (v > w) ? w : v;
                end else begin
                    cur[i] = int'($urandom_range(0, w));
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
            send(); wait_valid(lat);
            compared++;
            if (lat != 8 || obs !== exp_vec()) begin
                mismatched++;
                $display("FAIL random_%0d: lat=%0d got %h want lat=8 %h", n, lat, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, nv;
        nv = 0;
        set_cur(3000, 3000, 12000, 3000, 3000, 12000);
        send();
        for (int k = 1; k <= 4; k++) begin @(negedge clk_in); sample_in = 1'b0; end
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < 6; i++) macc[i] = 0;
        mprimed = 1'b0;
        for (int k = 0; k < 12; k++) begin @(negedge clk_in); if (out_valid) nv++; end
        compared++;
        if (nv != 0 || obs !== 117'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_abort: valids=%0d obs=%h busy=%b want 0/0/0", nv, obs, busy);
        end
        set_cur(100, 4000, 16000, 3900, 50, 10);
        send(); wait_valid(lat);
        compared++;
        if (smooth_x_bottom !== 12'd100 || obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL reset_mid_resnap: got %h want %h", obs, exp_vec());
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin cur[i] = 0; macc[i] = 0; end
        mprimed = 1'b0;
        test_reset();
        test_prime();
        test_ema();
        test_wrap();
        test_dir();
        test_dropped();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
